div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
// - Multi-cycle restoring divider, shared by the EX stage for DIV/DIVU; one quotient bit per cycle.
// - EX raises start_i with operands and holds the pipeline until ready_o. It writes {rem,quo} into HI/LO.
// - Sequencing FSM lives here; EX only drives the request and consumes the result.
// PARAMETERS
// - WIDTH  32  operand width; iteration count = WIDTH
// PORTS
// - clk         in   1        clock, rising edge
// - rst         in   1        reset, synchronous, active-high
// - start_i     in   1        divide request; held high by EX until result consumed
// - annul_i     in   1        cancel in-flight op (branch/exception flush)
// - signed_i    in   1        1 = DIV (two's complement), 0 = DIVU
// - opdata1_i   in   WIDTH    dividend, sampled only when request accepted
// - opdata2_i   in   WIDTH    divisor, sampled only when request accepted
// - result_o    out  2*WIDTH  {remainder, quotient}
// - ready_o     out  1        result_o valid
// - busy_o      out  1        op in progress (state ON or BYZERO)
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, result_o=0, ready_o=0. busy_o=0. rst wins over all inputs, including mid-op.
// - States IDLE, BYZERO, ON, END. busy_o is decoded from state. ready_o/result_o are registered.
// - IDLE: start_i & !annul_i accepts the request:
//   - opdata2_i==0 -> BYZERO.
//   - else -> ON, cnt=0; latch |op1|,|op2| (abs only if signed_i), sign of op1, sign of op2, signed_i.
//   - else stay; ready_o=0, result_o=0.
// - BYZERO: annul_i -> IDLE; else result_o=0, ready_o=1, -> END.
// - ON: annul_i -> IDLE, partial state discarded, ready_o stays 0. Otherwise:
//   - cnt<WIDTH: one restoring step, cnt++.
//     - step: {rem,dvd} shifted left 1; trial = rem - divisor (WIDTH+1 bits).
//     - trial>=0: rem=trial, quotient bit=1; else quotient bit=0.
//   - cnt==WIDTH: sign-correct, load result_o, ready_o=1, -> END.
//     - quo negated if signed and operand signs differ; rem negated if signed and dividend negative.
// - END: hold result_o and ready_o=1 while start_i=1; annul_i ignored.
//   - start_i=0 -> IDLE, ready_o=0, result_o=0.
// - Latency: accept edge at cycle T. Nonzero divisor: ready_o high from cycle T+WIDTH+2 (34 for WIDTH=32).
//   Divisor zero: ready_o high from T+2.
// - Back-to-back: start_i must drop >=1 cycle after ready_o. A new request is accepted only in IDLE.
// - Operand changes after acceptance are ignored.
// - Signed overflow: -2^(W-1) / -1 -> quo=0x80000000 (wraps), rem=0. No trap is raised.
// - Arithmetic wraps modulo 2^WIDTH. Abs of -2^(W-1) is taken as unsigned 2^(W-1).
// STRUCTURE
// - Shared defines header gets:
//   - state encodings DivFree/DivByZero/DivOn/DivEnd
//   - DivResultReady/DivResultNotReady
//   - DivStart/DivStop
//   - DivResultBus (2*WIDTH)
// - Sub-module div_step: combinational single restoring iteration,
//   (rem, dvd, divisor) -> (rem', dvd', qbit). FSM and counter stay in div_seq.
// TESTING
// - DIVU 100/7 -> 34 cycles after accept ready_o=1, result_o={32'd2,32'd14}. busy_o high cycles T+1..T+33.
// - DIV -7/2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF. DIV 7/-2 -> quo=0xFFFFFFFD, rem=1.
// - DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0. DIVU 0xFFFFFFFF/1 -> quo=0xFFFFFFFF, rem=0.
// - 5/0 -> ready_o at T+2, result_o=0. Hold start 5 cycles -> result stable. Drop start -> IDLE, ready_o=0.
// - annul_i at cycle T+10 -> IDLE next cycle, ready_o never asserts.
//   New 9/3 accepted immediately after -> quo=3, rem=0 with full 34-cycle latency.
// - rst at T+15 -> next cycle ready_o=0, result_o=0, busy_o=0. Request after rst drop completes normally.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  // Sequencer states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // {remainder, quotient} bus width at the default operand width
  localparam int DivResultBus = 2 * DIV_WIDTH;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,dvd} left by one, trial-subtract
// the divisor, keep the difference when it is non-negative. Quotient bits shift
// into the low end of dvd, so after WIDTH steps dvd holds the quotient.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // WIDTH+1 bits is enough: rem < divisor, so the trial lies in (-2^W, 2^W)
  always_comb begin
    w_shift = {i_rem, i_dvd[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_dsr};
    o_qbit  = ~w_trial[WIDTH];
    o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    o_dvd   = {i_dvd[WIDTH-2:0], o_qbit};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, sign correction on the final cycle, result held until EX drops
// its request.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         r_state, w_state_n;
  logic [CW-1:0]      r_cnt, w_cnt_n;
  logic [WIDTH-1:0]   r_rem, w_rem_n;
  logic [WIDTH-1:0]   r_dvd, w_dvd_n;
  logic [WIDTH-1:0]   r_dsr, w_dsr_n;
  logic               r_sign1, w_sign1_n;
  logic               r_sign2, w_sign2_n;
  logic               r_signed, w_signed_n;
  logic [2*WIDTH-1:0] r_result, w_result_n;
  logic               r_ready, w_ready_n;

  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH-1:0]   w_step_rem, w_step_dvd;
  logic               w_step_qbit;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dsr  (r_dsr),
    .o_rem  (w_step_rem),
    .o_dvd  (w_step_dvd),
    .o_qbit (w_step_qbit)
  );

  // Operand magnitudes and final sign correction; -2^(W-1) maps to itself,
  // which reads correctly as the unsigned magnitude 2^(W-1).
  always_comb begin
    w_abs1    = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    w_abs2    = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -r_dvd : r_dvd;
    w_rem_fix = (r_signed && r_sign1) ? -r_rem : r_rem;
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_rem_n    = r_rem;
    w_dvd_n    = r_dvd;
    w_dsr_n    = r_dsr;
    w_sign1_n  = r_sign1;
    w_sign2_n  = r_sign2;
    w_signed_n = r_signed;
    w_result_n = r_result;
    w_ready_n  = r_ready;
    case (r_state)
      DivFree: begin
        w_ready_n  = DivResultNotReady;
        w_result_n = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_n = DivByZero;
          end else begin
            w_state_n  = DivOn;
            w_cnt_n    = '0;
            w_rem_n    = '0;
            w_dvd_n    = w_abs1;
            w_dsr_n    = w_abs2;
            w_sign1_n  = opdata1_i[WIDTH-1];
            w_sign2_n  = opdata2_i[WIDTH-1];
            w_signed_n = signed_i;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          w_state_n = DivFree;
        end else begin
          w_result_n = '0;
          w_ready_n  = DivResultReady;
          w_state_n  = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          w_state_n = DivFree;
          w_ready_n = DivResultNotReady;
        end else if (r_cnt != CW'(WIDTH)) begin
          w_rem_n = w_step_rem;
          w_dvd_n = w_step_dvd;
          w_cnt_n = r_cnt + 1'b1;
        end else begin
          w_result_n = {w_rem_fix, w_quo_fix};
          w_ready_n  = DivResultReady;
          w_state_n  = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_state_n  = DivFree;
          w_ready_n  = DivResultNotReady;
          w_result_n = '0;
        end
      end
      default: w_state_n = DivFree;
    endcase
  end

  // State and datapath registers; reset overrides everything, mid-op included
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_signed <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_rem    <= w_rem_n;
      r_dvd    <= w_dvd_n;
      r_dsr    <= w_dsr_n;
      r_sign1  <= w_sign1_n;
      r_sign2  <= w_sign2_n;
      r_signed <= w_signed_n;
      r_result <= w_result_n;
      r_ready  <= w_ready_n;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == DivOn) || (r_state == DivByZero);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table of divides with hand-computed
// results and latencies, plus sequences for annul, div-by-zero and reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller has start_i and operands set up; first tick is the accept edge.
  // Returns ticks until ready_o (accept tick counts as 1) and busy-high ticks.
  task automatic wait_ready(input bit scramble, output int lat, output int busy_hi);
    tick();
    lat = 1;
    busy_hi = 0;
    if (scramble) begin
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_i  = ~signed_i;
    end
    while (!ready_o && lat < 60) begin
      if (busy_o) busy_hi++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input int hold);
    int lat, bh;
    signed_i  = v.sgn;
    opdata1_i = v.a;
    opdata2_i = v.b;
    start_i   = 1'b1;
    wait_ready(1'b1, lat, bh);
    check($sformatf("%s latency", v.name), 64'(lat), 64'(v.exp_lat));
    check($sformatf("%s busy cycles", v.name), 64'(bh), 64'(v.exp_lat - 1));
    check($sformatf("%s result", v.name), result_o, {v.exp_r, v.exp_q});
    check($sformatf("%s busy at ready", v.name), 64'(busy_o), 64'd0);
    // Hold: result must stay put, annul ignored while the result is held
    for (int i = 0; i < hold; i++) begin
      annul_i = (i == 1);
      tick();
      check($sformatf("%s hold%0d", v.name, i), {63'd0, ready_o}, 64'd1);
      check($sformatf("%s hold%0d result", v.name, i), result_o, {v.exp_r, v.exp_q});
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check($sformatf("%s drop ready", v.name), 64'(ready_o), 64'd0);
    check($sformatf("%s drop result", v.name), result_o, 64'd0);
    check($sformatf("%s drop busy", v.name), 64'(busy_o), 64'd0);
  endtask

  initial begin
    int lat, bh;
    bit saw_ready;

    vecs[0]  = '{"divu 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
    vecs[1]  = '{"div -7/2",          1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
    vecs[2]  = '{"div 7/-2",          1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34};
    vecs[3]  = '{"div min/-1",        1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34};
    vecs[4]  = '{"divu max/1",        1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          34};
    vecs[5]  = '{"divu 5/0",          1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[6]  = '{"div -100/-7",       1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  34};
    vecs[7]  = '{"divu min/max",      1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34};
    vecs[8]  = '{"divu 3/10",         1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          34};
    vecs[9]  = '{"divu max/max",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          34};
    vecs[10] = '{"div 0/-5",          1'b1, 32'd0,          32'hFFFF_FFFB,  32'd0,          32'd0,          34};
    vecs[11] = '{"div maxpos/min",    1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  34};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_op(vecs[i], (i == 5) ? 5 : 2);

    // Annul in BYZERO returns to IDLE without a result
    signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    check("byzero busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    tick();
    check("byzero annul ready", 64'(ready_o), 64'd0);
    check("byzero annul busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    tick();

    // Annul at T+10, then 9/3 accepted on the next edge with full latency
    saw_ready = 1'b0;
    signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      saw_ready |= ready_o;
      tick();
    end
    annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    tick();
    saw_ready |= ready_o;
    check("annul ready never", 64'(saw_ready), 64'd0);
    check("annul busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    wait_ready(1'b1, lat, bh);
    check("after annul latency", 64'(lat), 64'd34);
    check("after annul result", result_o, {32'd0, 32'd3});
    start_i = 1'b0;
    tick();

    // Reset at T+15 with the request still high
    signed_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    check("midop rst ready", 64'(ready_o), 64'd0);
    check("midop rst result", result_o, 64'd0);
    check("midop rst busy", 64'(busy_o), 64'd0);
    rst = 1'b0; start_i = 1'b0;
    tick();
    run_op(vecs[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
